// File: rtl/ctl_round_pkg.sv
// rtl/ctl_round_pkg.sv - round sequencer states, default constants and timer sizing
package ctl_round_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FLYING,
    HIT_WAIT,
    FLYAWAY,
    TALLY,
    INTERMISSION,
    GAME_OVER
  } round_state_t;

  localparam int DUCKS_PER_ROUND_DEF     = 10;
  localparam int SHOTS_PER_DUCK_DEF      = 3;
  localparam int PASS_HITS_DEF           = 6;
  localparam int FLY_TIMEOUT_FRAMES_DEF  = 300;
  localparam int EVENT_FRAMES_DEF        = 60;
  localparam int INTERMISSION_FRAMES_DEF = 120;
  localparam int MAX_ROUND_DEF           = 15;

  // Bits needed to hold the longest frame interval the sequencer waits for.
  function automatic int timer_width(input int fly_frames, input int inter_frames);
    int longest;
    longest = (fly_frames > inter_frames) ? fly_frames : inter_frames;
    return $clog2(longest + 1);
  endfunction

  localparam int TIMER_W = timer_width(FLY_TIMEOUT_FRAMES_DEF, INTERMISSION_FRAMES_DEF);

  // Duck speed tracks the round number, starting at 0 in round 1 and capped at 7.
  function automatic logic [2:0] speed_of(input logic [3:0] rnd);
    logic [3:0] minus_one;
    minus_one = rnd - 4'd1;
    if (rnd == 4'd0) return 3'd0;
    if (rnd > 4'd8) return 3'd7;
    return minus_one[2:0];
  endfunction

endpackage

// File: rtl/ctl_round_frame_timer.sv
// rtl/ctl_round_frame_timer.sv - pause-gated frame counter, cleared on each state entry
import ctl_round_pkg::*;

module frame_timer #(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         new_frame,
  input  logic         pause,
  output logic [W-1:0] count
);

  // Count unpaused frames; saturate rather than wrap so a long wait never looks short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (new_frame && !pause && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ctl_round.sv
// rtl/ctl_round.sv - Duck Hunt round sequencer; perfect-round bonus under CTL_ROUND_PERFECT_BONUS_EN
import ctl_round_pkg::*;

module ctl_round #(
  parameter int DUCKS_PER_ROUND     = DUCKS_PER_ROUND_DEF,
  parameter int SHOTS_PER_DUCK      = SHOTS_PER_DUCK_DEF,
  parameter int PASS_HITS           = PASS_HITS_DEF,
  parameter int FLY_TIMEOUT_FRAMES  = FLY_TIMEOUT_FRAMES_DEF,
  parameter int EVENT_FRAMES        = EVENT_FRAMES_DEF,
  parameter int INTERMISSION_FRAMES = INTERMISSION_FRAMES_DEF,
  parameter int MAX_ROUND           = MAX_ROUND_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       game_start,
  input  logic       pause,
  input  logic       hit,
  input  logic       shot_fired,
  output logic       duck_launch,
  output logic       duck_flyaway,
  output logic [3:0] round,
  output logic [3:0] duck_idx,
  output logic [3:0] round_hits,
  output logic [2:0] speed_level,
  output logic       game_over,
  output logic       perfect
);

`ifdef CTL_ROUND_PERFECT_BONUS_EN
  // A perfect intermission runs twice as long, so the timer must reach that far.
  localparam int TW = timer_width(FLY_TIMEOUT_FRAMES, 2 * INTERMISSION_FRAMES);
  localparam logic [TW-1:0] INTER2_T = TW'(2 * INTERMISSION_FRAMES);
`else
  localparam int TW = timer_width(FLY_TIMEOUT_FRAMES, INTERMISSION_FRAMES);
`endif

  localparam logic [TW-1:0] FLY_T     = TW'(FLY_TIMEOUT_FRAMES);
  localparam logic [TW-1:0] EVENT_T   = TW'(EVENT_FRAMES);
  localparam logic [TW-1:0] INTER_T   = TW'(INTERMISSION_FRAMES);
  localparam logic [3:0]    LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]    PASS_T    = 4'(PASS_HITS);
  localparam logic [3:0]    MAX_R     = 4'(MAX_ROUND);
  localparam logic [2:0]    SHOTS_T   = 3'(SHOTS_PER_DUCK);

  round_state_t  state, state_d;
  logic [3:0]    round_d, idx_d, hits_d;
  logic [2:0]    shots_left, shots_d;
  logic [TW-1:0] count;
  logic [TW-1:0] inter_limit;
  logic          tick;
  logic          timer_clear;

  assign tick        = new_frame && !pause;
  assign timer_clear = game_start || (state_d != state);

  frame_timer #(.W(TW)) u_frame_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .new_frame (new_frame),
    .pause     (pause),
    .count     (count)
  );

`ifdef CTL_ROUND_PERFECT_BONUS_EN
  logic perfect_d;
  assign inter_limit = (round_hits == 4'(DUCKS_PER_ROUND)) ? INTER2_T : INTER_T;
  assign perfect_d   = (state_d == INTERMISSION) && (hits_d == 4'(DUCKS_PER_ROUND));

  // Perfect flag follows the registered state so it covers the whole intermission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perfect <= 1'b0;
    else     perfect <= perfect_d;
  end
`else
  assign inter_limit = INTER_T;
  assign perfect     = 1'b0;
`endif

  // Next-state and counter updates; restart beats everything, pause freezes the rest.
  always_comb begin
    state_d = state;
    round_d = round;
    idx_d   = duck_idx;
    hits_d  = round_hits;
    shots_d = shots_left;
    if (game_start) begin
      state_d = LAUNCH;
      round_d = 4'd1;
      idx_d   = 4'd0;
      hits_d  = 4'd0;
    end else if (!pause) begin
      case (state)
        IDLE: ;
        LAUNCH: begin
          shots_d = SHOTS_T;
          state_d = FLYING;
        end
        FLYING: begin
          if (hit) begin
            if (round_hits != 4'd15) hits_d = round_hits + 4'd1;
            state_d = HIT_WAIT;
          end else begin
            if (shot_fired && (shots_left != 3'd0)) shots_d = shots_left - 3'd1;
            // Out of shots only ends the duck on a frame boundary, leaving room for a late hit.
            if ((tick && (shots_left == 3'd0)) || (count >= FLY_T)) state_d = FLYAWAY;
          end
        end
        HIT_WAIT, FLYAWAY: begin
          if (count >= EVENT_T) begin
            if (duck_idx == LAST_DUCK) begin
              state_d = TALLY;
            end else begin
              idx_d   = duck_idx + 4'd1;
              state_d = LAUNCH;
            end
          end
        end
        TALLY: state_d = (round_hits >= PASS_T) ? INTERMISSION : GAME_OVER;
        INTERMISSION: begin
          if (count >= inter_limit) begin
            if (round != MAX_R) round_d = round + 4'd1;
            idx_d   = 4'd0;
            hits_d  = 4'd0;
            state_d = LAUNCH;
          end
        end
        GAME_OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and all visible outputs update together one cycle after the trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      round        <= 4'd1;
      duck_idx     <= 4'd0;
      round_hits   <= 4'd0;
      shots_left   <= 3'd0;
      duck_launch  <= 1'b0;
      duck_flyaway <= 1'b0;
      game_over    <= 1'b0;
      speed_level  <= 3'd0;
    end else begin
      state        <= state_d;
      round        <= round_d;
      duck_idx     <= idx_d;
      round_hits   <= hits_d;
      shots_left   <= shots_d;
      // Only the entry into LAUNCH fires, so a restart during LAUNCH cannot double-pulse.
      duck_launch  <= (state_d == LAUNCH) && (state != LAUNCH);
      duck_flyaway <= (state_d == FLYAWAY);
      game_over    <= (state_d == GAME_OVER);
      speed_level  <= speed_of(round_d);
    end
  end

endmodule

// File: tb/tb_ctl_round.sv
// tb/tb_ctl_round.sv - directed bench for ctl_round; expectations follow CTL_ROUND_PERFECT_BONUS_EN
module tb_ctl_round;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       game_start = 1'b0;
  logic       pause = 1'b0;
  logic       hit = 1'b0;
  logic       shot_fired = 1'b0;
  logic       duck_launch;
  logic       duck_flyaway;
  logic [3:0] round;
  logic [3:0] duck_idx;
  logic [3:0] round_hits;
  logic [2:0] speed_level;
  logic       game_over;
  logic       perfect;

  int vectors = 0;
  int errors = 0;
  int launch_cnt = 0;
  int consec_launch = 0;
  int launch_mark = 0;
  logic prev_launch = 1'b0;

`ifdef CTL_ROUND_PERFECT_BONUS_EN
  localparam int EXP_PERFECT = 1;
  localparam int EXP_ROUND_AT_120 = 1;
`else
  localparam int EXP_PERFECT = 0;
  localparam int EXP_ROUND_AT_120 = 2;
`endif

  ctl_round dut (
    .clk          (clk),
    .rst          (rst),
    .new_frame    (new_frame),
    .game_start   (game_start),
    .pause        (pause),
    .hit          (hit),
    .shot_fired   (shot_fired),
    .duck_launch  (duck_launch),
    .duck_flyaway (duck_flyaway),
    .round        (round),
    .duck_idx     (duck_idx),
    .round_hits   (round_hits),
    .speed_level  (speed_level),
    .game_over    (game_over),
    .perfect      (perfect)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (duck_launch) launch_cnt++;
    if (duck_launch && prev_launch) consec_launch++;
    prev_launch = duck_launch;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  task automatic duck_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    frames(60);
    step();
  endtask

  task automatic duck_miss();
    for (int i = 0; i < 3; i++) begin
      shot_fired = 1'b1;
      step();
      shot_fired = 1'b0;
    end
    frames(61);
    step();
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_round", int'(round), 1);
    chk("rst_idx", int'(duck_idx), 0);
    chk("rst_hits", int'(round_hits), 0);
    chk("rst_speed", int'(speed_level), 0);
    chk("rst_launch", int'(duck_launch), 0);
    chk("rst_flyaway", int'(duck_flyaway), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_perfect", int'(perfect), 0);

    pulse_start();
    chk("start_launch", int'(duck_launch), 1);
    chk("start_round", int'(round), 1);
    chk("start_idx", int'(duck_idx), 0);
    step();
    chk("launch_one_cycle", int'(duck_launch), 0);

    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("hit_count", int'(round_hits), 1);
    frames(59);
    chk("hitwait_idx_hold", int'(duck_idx), 0);
    frame();
    chk("hitwait_idx_next", int'(duck_idx), 1);
    chk("hitwait_relaunch", int'(duck_launch), 1);
    step();
    chk("launch_count_2", launch_cnt, 2);

    for (int i = 0; i < 3; i++) begin
      shot_fired = 1'b1;
      step();
      shot_fired = 1'b0;
    end
    chk("shots_no_early_flyaway", int'(duck_flyaway), 0);
    frame();
    chk("shots_flyaway", int'(duck_flyaway), 1);
    frames(59);
    chk("flyaway_hold", int'(duck_flyaway), 1);
    chk("flyaway_idx_hold", int'(duck_idx), 1);
    frame();
    chk("flyaway_end", int'(duck_flyaway), 0);
    chk("flyaway_idx_next", int'(duck_idx), 2);
    step();

    frames(299);
    chk("timeout_299", int'(duck_flyaway), 0);
    frame();
    chk("timeout_300", int'(duck_flyaway), 1);
    frames(60);
    chk("timeout_idx_next", int'(duck_idx), 3);
    step();

    for (int i = 0; i < 5; i++) duck_hit();
    duck_miss();
    duck_miss();
    chk("r1_hits", int'(round_hits), 6);
    chk("r1_idx", int'(duck_idx), 9);
    chk("r1_launches", launch_cnt, 10);
    chk("r1_perfect", int'(perfect), 0);
    frames(119);
    chk("inter_round_hold", int'(round), 1);
    frame();
    chk("inter_round_next", int'(round), 2);
    chk("inter_speed", int'(speed_level), 1);
    chk("inter_hits_clr", int'(round_hits), 0);
    chk("inter_idx_clr", int'(duck_idx), 0);
    step();

    for (int i = 0; i < 5; i++) duck_hit();
    for (int i = 0; i < 5; i++) duck_miss();
    chk("go_flag", int'(game_over), 1);
    chk("go_hits", int'(round_hits), 5);
    launch_mark = launch_cnt;
    frames(200);
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    chk("go_hold", int'(game_over), 1);
    chk("go_hit_ignored", int'(round_hits), 5);
    chk("go_no_launch", launch_cnt, launch_mark);
    pulse_start();
    chk("restart_round", int'(round), 1);
    chk("restart_hits", int'(round_hits), 0);
    chk("restart_speed", int'(speed_level), 0);
    chk("restart_go_clr", int'(game_over), 0);
    chk("restart_launch", int'(duck_launch), 1);
    step();

    frames(100);
    pause = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ((i % 100) == 50) begin
        hit = 1'b1;
        shot_fired = 1'b1;
      end
      frame();
      hit = 1'b0;
      shot_fired = 1'b0;
    end
    chk("pause_no_timeout", int'(duck_flyaway), 0);
    chk("pause_hits", int'(round_hits), 0);
    chk("pause_idx", int'(duck_idx), 0);
    pause = 1'b0;
    frames(199);
    chk("resume_299", int'(duck_flyaway), 0);
    frame();
    chk("resume_300", int'(duck_flyaway), 1);

    pulse_start();
    step();
    for (int i = 0; i < 10; i++) duck_hit();
    chk("perf_hits", int'(round_hits), 10);
    chk("perf_flag", int'(perfect), EXP_PERFECT);
    frames(119);
    chk("perf_round_119", int'(round), 1);
    chk("perf_flag_mid", int'(perfect), EXP_PERFECT);
    frame();
    chk("perf_round_120", int'(round), EXP_ROUND_AT_120);
    frames(120);
    chk("perf_round_240", int'(round), 2);
    chk("perf_flag_after", int'(perfect), 0);
    chk("perf_hits_clr", int'(round_hits), 0);

    chk("no_consecutive_launch", consec_launch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
